// File: rtl/alu.sv
// Y86-64 execute-stage ALU: add, sub, and, xor on 64-bit signed operands.
// The result and the signed-overflow flag are registered, so both appear one cycle later.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] num1,
  input  logic [63:0] num2,
  input  logic [1:0]  operation,
  output logic [63:0] result,
  output logic        overflow_flag
);

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpXor = 2'b11
  } alu_op_e;

  alu_op_e     op;
  logic        sub;
  logic [63:0] operand_b;
  logic [63:0] sum;
  logic        carry_out;
  logic        arith_ovf;
  logic [63:0] result_d;
  logic        overflow_d;

  assign op = alu_op_e'(operation);
  assign sub = (op == OpSub);

  // Add and sub share one adder: sub inverts B and forces carry-in to 1.
  assign operand_b = sub ? ~num2 : num2;
  assign {carry_out, sum} = {1'b0, num1} + {1'b0, operand_b} + {64'd0, sub};

  // The effective B sign folds the add and sub overflow rules into one test.
  assign arith_ovf = (num1[63] == operand_b[63]) && (sum[63] != num1[63]);

  always_comb begin
    result_d   = sum;
    overflow_d = 1'b0;
    unique case (op)
      OpAdd, OpSub: begin
        result_d   = sum;
        overflow_d = arith_ovf;
      end
      OpAnd: result_d = num1 & num2;
      OpXor: result_d = num1 ^ num2;
      default: begin
        result_d   = sum;
        overflow_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result        <= 64'h0;
      overflow_flag <= 1'b0;
    end else begin
      result        <= result_d;
      overflow_flag <= overflow_d;
    end
  end

  logic unused_carry;
  assign unused_carry = carry_out;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: exact-integer reference model compared every cycle,
// plus hand-computed corner cases and asynchronous reset checks.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [63:0] num1;
  logic [63:0] num2;
  logic [1:0]  operation;
  logic [63:0] result;
  logic        overflow_flag;

  int tests;
  int fails;
  bit check_en;

  logic [63:0] exp_res;
  logic        exp_ovf;

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .num1         (num1),
    .num2         (num2),
    .operation    (operation),
    .result       (result),
    .overflow_flag(overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic signed [64:0] SMax = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] SMin = 65'sh1_8000_0000_0000_0000;

  // Exact 65-bit signed arithmetic; overflow means the true value leaves the 64-bit range.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic [1:0] op, output logic [63:0] r,
                                output logic o);
    logic signed [64:0] wa, wb, wide;
    wa = $signed({a[63], a});
    wb = $signed({b[63], b});
    r = '0;
    o = 1'b0;
    case (op)
      2'd0, 2'd1: begin
        wide = (op == 2'd0) ? wa + wb : wa - wb;
        r = wide[63:0];
        o = (wide > SMax) || (wide < SMin);
      end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_res = 64'h0;
      exp_ovf = 1'b0;
    end else begin
      model(num1, num2, operation, exp_res, exp_ovf);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      tests++;
      if (result !== exp_res || overflow_flag !== exp_ovf) begin
        fails++;
        $display("FAIL model t=%0t: got res=%h ovf=%b, want res=%h ovf=%b",
                 $time, result, overflow_flag, exp_res, exp_ovf);
      end
    end
  end

  task automatic expect_now(input string name, input logic [63:0] er, input logic eo);
    tests++;
    if (result !== er || overflow_flag !== eo) begin
      fails++;
      $display("FAIL %s: got res=%h ovf=%b, want res=%h ovf=%b",
               name, result, overflow_flag, er, eo);
    end
  endtask

  // Called right after a negedge; inputs sampled at the next posedge, checked at the following negedge.
  task automatic apply_check(input string name, input logic [63:0] a, input logic [63:0] b,
                             input logic [1:0] op, input logic [63:0] er, input logic eo);
    num1 = a;
    num2 = b;
    operation = op;
    @(posedge clk);
    @(negedge clk);
    expect_now(name, er, eo);
  endtask

  task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    num1 = a;
    num2 = b;
    operation = op;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] a, b;
    logic [31:0] lo;
    tests = 0;
    fails = 0;
    check_en = 1'b0;
    exp_res = 64'h0;
    exp_ovf = 1'b0;
    rst_n = 1'b0;
    num1 = 64'hFFFF_FFFF_FFFF_FFFB;
    num2 = 64'd107;
    operation = 2'b00;
    #3;
    expect_now("reset_immediate", 64'h0, 1'b0);

    @(negedge clk);
    expect_now("reset_hold_edge", 64'h0, 1'b0);
    rst_n = 1'b1;
    check_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expect_now("first_load_102", 64'd102, 1'b0);

    apply_check("add_max_plus_1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00,
                64'h8000_0000_0000_0000, 1'b1);
    apply_check("sub_min_minus_1", 64'h8000_0000_0000_0000, 64'd1, 2'b01,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    apply_check("sub_m5_107", 64'hFFFF_FFFF_FFFF_FFFB, 64'd107, 2'b01,
                64'hFFFF_FFFF_FFFF_FF90, 1'b0);
    apply_check("add_m1_p1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'h0, 1'b0);
    apply_check("and_m5_107", 64'hFFFF_FFFF_FFFF_FFFB, 64'd107, 2'b10, 64'h6B, 1'b0);
    apply_check("xor_m5_107", 64'hFFFF_FFFF_FFFF_FFFB, 64'd107, 2'b11,
                64'hFFFF_FFFF_FFFF_FF90, 1'b0);
    apply_check("sub_min_minus_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01,
                64'h0, 1'b0);
    apply_check("add_min_plus_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00,
                64'h0, 1'b1);

    // Sign-extended 32-bit operands.
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 10; i++) begin
        a = {{32{1'b0}}, $urandom()};
        b = {{32{1'b0}}, $urandom()};
        a = {{32{a[31]}}, a[31:0]};
        b = {{32{b[31]}}, b[31:0]};
        apply(a, b, 2'(op));
      end
    end

    // Full 64-bit operands; every other pair forces a carry across bit 31/32.
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 10; i++) begin
        lo = (i % 2 == 0) ? 32'hFFFF_FFFF : $urandom();
        a = {$urandom(), 32'h0};
        a = a | {32'h0, lo};
        b = {$urandom(), $urandom()};
        if (i % 2 == 0) b[0] = 1'b1;
        apply(a, b, 2'(op));
      end
    end

    // Op changes every cycle with fixed operands.
    for (int i = 0; i < 8; i++) apply(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_F0F0_F0F0, 2'(i % 4));

    // Last applied op was xor, so the output is non-zero before the mid-cycle reset.
    #2;
    expect_now("pre_reset_xor", 64'h1D3B_5977_6A4C_2E00, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_now("reset_midstream", 64'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_check("after_reset_add", 64'd40, 64'd2, 2'b00, 64'd42, 1'b0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
